// File: rtl/bullet_hit_detector.sv
// Per-frame bullet/enemy collision scanner: snapshots positions on frame_tick,
// tests one (bullet, enemy) pair per clock and reports hits as one-cycle pulses.
module bullet_hit_detector #(
    parameter int unsigned BULLET_COUNT = 8,
    parameter int unsigned ENEMY_COUNT  = 4,
    parameter int unsigned BULLET_W     = 8,
    parameter int unsigned ENEMY_W      = 32,
    parameter int unsigned SCORE_W      = 16
) (
    input  logic                       clk25,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic [10*BULLET_COUNT-1:0] bullet_x,
    input  logic [10*BULLET_COUNT-1:0] bullet_y,
    input  logic [BULLET_COUNT-1:0]    bullet_active,
    input  logic [10*ENEMY_COUNT-1:0]  enemy_x,
    input  logic [10*ENEMY_COUNT-1:0]  enemy_y,
    input  logic [ENEMY_COUNT-1:0]     enemy_alive,
    output logic [BULLET_COUNT-1:0]    bullet_hit,
    output logic [ENEMY_COUNT-1:0]     enemy_kill,
    output logic [SCORE_W-1:0]         score,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned PW  = 10;
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned BW  = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
    localparam int unsigned EW  = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
    localparam int unsigned SW1 = SCORE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_e;

    state_e                   state_q, state_d;
    logic [BW-1:0]            b_q, b_d;
    logic [EW-1:0]            e_q, e_d;
    logic [BULLET_COUNT-1:0]  pb_q, pb_d;
    logic [ENEMY_COUNT-1:0]   pe_q, pe_d;
    logic [BULLET_COUNT-1:0]  hit_q, hit_d;
    logic [ENEMY_COUNT-1:0]   kill_q, kill_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;
    logic                     load_c;

    logic [PW-1:0]            sbx_q [BULLET_COUNT];
    logic [PW-1:0]            sby_q [BULLET_COUNT];
    logic [BULLET_COUNT-1:0]  sb_act_q;
    logic [PW-1:0]            sex_q [ENEMY_COUNT];
    logic [PW-1:0]            sey_q [ENEMY_COUNT];
    logic [ENEMY_COUNT-1:0]   se_alive_q;

    logic [CW-1:0]            bx_c, by_c, ex_c, ey_c;
    logic                     overlap_c;
    logic                     pair_hit_c;
    logic [SW1-1:0]           sum_c;

    // Frame snapshot, so live movement during a scan cannot disturb results
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BULLET_COUNT); i++) begin
                sbx_q[i] <= '0;
                sby_q[i] <= '0;
            end
            for (int i = 0; i < int'(ENEMY_COUNT); i++) begin
                sex_q[i] <= '0;
                sey_q[i] <= '0;
            end
            sb_act_q   <= '0;
            se_alive_q <= '0;
        end else if (load_c) begin
            for (int i = 0; i < int'(BULLET_COUNT); i++) begin
                sbx_q[i] <= bullet_x[10*i +: 10];
                sby_q[i] <= bullet_y[10*i +: 10];
            end
            for (int i = 0; i < int'(ENEMY_COUNT); i++) begin
                sex_q[i] <= enemy_x[10*i +: 10];
                sey_q[i] <= enemy_y[10*i +: 10];
            end
            sb_act_q   <= bullet_active;
            se_alive_q <= enemy_alive;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            b_q       <= '0;
            e_q       <= '0;
            pb_q      <= '0;
            pe_q      <= '0;
            hit_q     <= '0;
            kill_q    <= '0;
            score_q   <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            e_q       <= e_d;
            pb_q      <= pb_d;
            pe_q      <= pe_d;
            hit_q     <= hit_d;
            kill_q    <= kill_d;
            score_q   <= score_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Coordinates widened by one bit so box edges near 1023 cannot wrap
    always_comb begin
        bx_c = {1'b0, sbx_q[b_q]};
        by_c = {1'b0, sby_q[b_q]};
        ex_c = {1'b0, sex_q[e_q]};
        ey_c = {1'b0, sey_q[e_q]};
        overlap_c = (bx_c < ex_c + CW'(ENEMY_W)) && (ex_c < bx_c + CW'(BULLET_W)) &&
                    (by_c < ey_c + CW'(ENEMY_W)) && (ey_c < by_c + CW'(BULLET_W));
        pair_hit_c = sb_act_q[b_q] && se_alive_q[e_q] && !pb_q[b_q] && !pe_q[e_q] && overlap_c;
    end

    always_comb begin
        sum_c = {1'b0, score_q};
        for (int i = 0; i < int'(ENEMY_COUNT); i++) begin
            sum_c = sum_c + SW1'(pe_q[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        e_d       = e_q;
        pb_d      = pb_q;
        pe_d      = pe_q;
        hit_d     = '0;
        kill_d    = '0;
        score_d   = score_q;
        overrun_d = overrun_q;
        load_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    load_c  = 1'b1;
                    pb_d    = '0;
                    pe_d    = '0;
                    b_d     = '0;
                    e_d     = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (pair_hit_c) begin
                    pb_d[b_q] = 1'b1;
                    pe_d[e_q] = 1'b1;
                end
                // Bullet index is major, enemy index minor
                if (e_q == EW'(ENEMY_COUNT - 1)) begin
                    e_d = '0;
                    if (b_q == BW'(BULLET_COUNT - 1)) begin
                        state_d = ST_REPORT;
                    end else begin
                        b_d = b_q + BW'(1);
                    end
                end else begin
                    e_d = e_q + EW'(1);
                end
            end
            ST_REPORT: begin
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                hit_d   = pb_q;
                kill_d  = pe_q;
                score_d = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bullet_hit = hit_q;
    assign enemy_kill = kill_q;
    assign score      = score_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Bench for bullet_hit_detector: directed spec scenarios plus randomized frames
// compared against a greedy pair-scan reference model.
module tb_bullet_hit_detector;

    localparam int BC = 8;
    localparam int EC = 4;

    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic            rst;
    logic            frame_tick;
    logic            frame_tick_s;
    logic [10*BC-1:0] bullet_x, bullet_y;
    logic [BC-1:0]   bullet_active;
    logic [10*EC-1:0] enemy_x, enemy_y;
    logic [EC-1:0]   enemy_alive;

    logic [BC-1:0]   bullet_hit, bullet_hit_s;
    logic [EC-1:0]   enemy_kill, enemy_kill_s;
    logic [15:0]     score;
    logic [2:0]      score_s;
    logic            busy, busy_s, overrun, overrun_s;

    bullet_hit_detector dut (
        .clk25(clk25), .rst(rst), .frame_tick(frame_tick),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
        .bullet_hit(bullet_hit), .enemy_kill(enemy_kill), .score(score),
        .busy(busy), .overrun(overrun)
    );

    // Narrow score copy used to reach saturation in a few frames
    bullet_hit_detector #(.SCORE_W(3)) dut_s (
        .clk25(clk25), .rst(rst), .frame_tick(frame_tick_s),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
        .bullet_hit(bullet_hit_s), .enemy_kill(enemy_kill_s), .score(score_s),
        .busy(busy_s), .overrun(overrun_s)
    );

    int unsigned bx [BC];
    int unsigned by [BC];
    int unsigned ex [EC];
    int unsigned ey [EC];
    logic [BC-1:0] bact;
    logic [EC-1:0] ealive;

    int checks   = 0;
    int failures = 0;
    logic [15:0] score_exp;

    task automatic drive_inputs();
        for (int i = 0; i < BC; i++) begin
            bullet_x[10*i +: 10] = 10'(bx[i]);
            bullet_y[10*i +: 10] = 10'(by[i]);
        end
        for (int i = 0; i < EC; i++) begin
            enemy_x[10*i +: 10] = 10'(ex[i]);
            enemy_y[10*i +: 10] = 10'(ey[i]);
        end
        bullet_active = bact;
        enemy_alive   = ealive;
    endtask

    task automatic clear_field();
        for (int i = 0; i < BC; i++) begin bx[i] = 0; by[i] = 0; end
        for (int i = 0; i < EC; i++) begin ex[i] = 0; ey[i] = 0; end
        bact   = '0;
        ealive = '0;
        drive_inputs();
    endtask

    task automatic randomize_field();
        for (int i = 0; i < BC; i++) begin
            bx[i] = $urandom_range(0, 250);
            by[i] = $urandom_range(0, 120);
        end
        for (int i = 0; i < EC; i++) begin
            ex[i] = $urandom_range(0, 250);
            ey[i] = $urandom_range(0, 120);
        end
        bact   = BC'($urandom);
        ealive = EC'($urandom);
        drive_inputs();
    endtask

    // Reference: walk bullets in order, each takes the first free enemy it overlaps
    function automatic void model(output logic [BC-1:0] h, output logic [EC-1:0] k);
        h = '0;
        k = '0;
        for (int b = 0; b < BC; b++) begin
            for (int e = 0; e < EC; e++) begin
                if (bact[b] && ealive[e] && !h[b] && !k[e] &&
                    bx[b] < ex[e] + 32 && ex[e] < bx[b] + 8 &&
                    by[b] < ey[e] + 32 && ey[e] < by[b] + 8) begin
                    h[b] = 1'b1;
                    k[e] = 1'b1;
                end
            end
        end
    endfunction

    // Caller is just past a negedge; tick is sampled at the next posedge (edge 0)
    task automatic run_frame(input string name, input logic [BC-1:0] exp_h,
                             input logic [EC-1:0] exp_k, input bit scramble,
                             input int extra_tick_at);
        int          stray;
        int unsigned sum;
        logic [BC-1:0] got_h;
        logic [EC-1:0] got_k;
        logic [15:0]   got_score;
        stray = 0;
        got_h = '0;
        got_k = '0;
        got_score = '0;
        frame_tick = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk25);
            frame_tick = (k == extra_tick_at);
            if (scramble && k == 5) randomize_field();
            if (k == 0 || k == 32) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_k%0d got=%b exp=1", name, k, busy);
                end
            end
            if (k == 33) begin
                got_h = bullet_hit;
                got_k = enemy_kill;
                got_score = score;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_after_report got=%b exp=0", name, busy);
                end
            end else if (bullet_hit !== '0 || enemy_kill !== '0) begin
                stray++;
            end
        end
        frame_tick = 1'b0;
        checks++;
        if (got_h !== exp_h || got_k !== exp_k) begin
            failures++;
            $display("FAIL %s pulses got hit=%h kill=%h exp hit=%h kill=%h",
                     name, got_h, got_k, exp_h, exp_k);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL %s stray_pulses got=%0d exp=0", name, stray);
        end
        sum = 32'(score_exp) + 32'($countones(exp_k));
        score_exp = (sum > 32'hFFFF) ? 16'hFFFF : 16'(sum);
        checks++;
        if (got_score !== score_exp) begin
            failures++;
            $display("FAIL %s score got=%h exp=%h", name, got_score, score_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_tick = 1'b0;
        frame_tick_s = 1'b0;
        clear_field();
        score_exp = '0;
        repeat (3) @(negedge clk25);
        checks++;
        if (bullet_hit !== '0 || enemy_kill !== '0 || score !== '0 ||
            busy !== 1'b0 || overrun !== 1'b0 || score_s !== '0) begin
            failures++;
            $display("FAIL reset_outputs got hit=%h kill=%h score=%h busy=%b ovr=%b score_s=%h exp all 0",
                     bullet_hit, enemy_kill, score, busy, overrun, score_s);
        end
        rst = 1'b0;
        @(negedge clk25);
    endtask

    task automatic test_basic();
        clear_field();
        bx[0] = 100; by[0] = 200; bact[0] = 1'b1;
        ex[0] = 96;  ey[0] = 190; ealive[0] = 1'b1;
        drive_inputs();
        run_frame("basic", 8'h01, 4'h1, 1'b0, -1);
    endtask

    task automatic test_edge_touch();
        clear_field();
        bx[2] = 132; by[2] = 50; bact[2] = 1'b1;
        ex[1] = 100; ey[1] = 50; ealive[1] = 1'b1;
        drive_inputs();
        run_frame("edge_touch", 8'h00, 4'h0, 1'b0, -1);
        bx[2] = 131;
        drive_inputs();
        run_frame("edge_overlap", 8'h04, 4'h2, 1'b0, -1);
        clear_field();
        bx[0] = 300; by[0] = 276; bact[0] = 1'b1;
        ex[0] = 292; ey[0] = 300; ealive[0] = 1'b1;
        drive_inputs();
        run_frame("edge_touch_low_y", 8'h00, 4'h0, 1'b0, -1);
    endtask

    task automatic test_bullet_priority();
        clear_field();
        bx[0] = 210; by[0] = 210; bact[0] = 1'b1;
        bx[1] = 205; by[1] = 205; bact[1] = 1'b1;
        ex[3] = 200; ey[3] = 200; ealive[3] = 1'b1;
        drive_inputs();
        run_frame("bullet_priority", 8'h01, 4'h8, 1'b0, -1);
    endtask

    task automatic test_enemy_priority();
        clear_field();
        bx[5] = 50; by[5] = 50; bact[5] = 1'b1;
        ex[0] = 40; ey[0] = 40; ealive[0] = 1'b1;
        ex[2] = 45; ey[2] = 45; ealive[2] = 1'b1;
        drive_inputs();
        run_frame("enemy_priority", 8'h20, 4'h1, 1'b0, -1);
    endtask

    task automatic test_inactive();
        clear_field();
        bx[3] = 50; by[3] = 50; bact[3] = 1'b0;
        ex[0] = 40; ey[0] = 40; ealive[0] = 1'b1;
        drive_inputs();
        run_frame("inactive_bullet", 8'h00, 4'h0, 1'b0, -1);
        bact[3] = 1'b1;
        ealive[0] = 1'b0;
        drive_inputs();
        run_frame("dead_enemy", 8'h00, 4'h0, 1'b0, -1);
    endtask

    task automatic test_no_wrap();
        clear_field();
        bx[0] = 1020; by[0] = 1020; bact[0] = 1'b1;
        ex[0] = 1000; ey[0] = 1000; ealive[0] = 1'b1;
        drive_inputs();
        run_frame("far_corner_hit", 8'h01, 4'h1, 1'b0, -1);
        bx[0] = 5; by[0] = 0;
        ex[0] = 1020; ey[0] = 0;
        drive_inputs();
        run_frame("no_wrap_miss", 8'h00, 4'h0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        clear_field();
        bx[4] = 10; by[4] = 10; bact[4] = 1'b1;
        ex[2] = 0;  ey[2] = 0;  ealive[2] = 1'b1;
        bx[6] = 400; by[6] = 300; bact[6] = 1'b1;
        ex[3] = 395; ey[3] = 290; ealive[3] = 1'b1;
        drive_inputs();
        run_frame("b2b_first", 8'h50, 4'hC, 1'b0, -1);
        run_frame("b2b_second", 8'h50, 4'hC, 1'b0, -1);
        @(negedge clk25);
        checks++;
        if (bullet_hit !== '0 || enemy_kill !== '0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_quiet got hit=%h kill=%h ovr=%b exp 0 0 0",
                     bullet_hit, enemy_kill, overrun);
        end
    endtask

    task automatic test_random();
        logic [BC-1:0] h;
        logic [EC-1:0] k;
        for (int n = 0; n < 24; n++) begin
            randomize_field();
            model(h, k);
            run_frame($sformatf("random%0d", n), h, k, 1'b1, -1);
        end
    endtask

    task automatic test_overrun();
        int late;
        late = 0;
        clear_field();
        bx[7] = 600; by[7] = 400; bact[7] = 1'b1;
        ex[1] = 590; ey[1] = 380; ealive[1] = 1'b1;
        drive_inputs();
        run_frame("overrun_frame", 8'h80, 4'h2, 1'b0, 10);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got=%b exp=1", overrun);
        end
        repeat (40) begin
            @(negedge clk25);
            if (bullet_hit !== '0 || enemy_kill !== '0 || busy !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("FAIL overrun_single_report got=%0d extra_cycles exp=0", late);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%b exp=1", overrun);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_s [3];
        logic [EC-1:0] alive_tab [3];
        exp_s[0] = 3'd4; exp_s[1] = 3'd6; exp_s[2] = 3'd7;
        alive_tab[0] = 4'hF; alive_tab[1] = 4'h3; alive_tab[2] = 4'h7;
        clear_field();
        for (int i = 0; i < EC; i++) begin
            ex[i] = 100 * i; ey[i] = 100;
            bx[i] = 100 * i + 4; by[i] = 104; bact[i] = 1'b1;
        end
        for (int f = 0; f < 3; f++) begin
            ealive = alive_tab[f];
            drive_inputs();
            frame_tick_s = 1'b1;
            @(negedge clk25);
            frame_tick_s = 1'b0;
            repeat (36) @(negedge clk25);
            checks++;
            if (score_s !== exp_s[f]) begin
                failures++;
                $display("FAIL saturate_frame%0d score got=%0d exp=%0d", f, score_s, exp_s[f]);
            end
        end
        checks++;
        if (score !== score_exp) begin
            failures++;
            $display("FAIL main_score_untouched got=%h exp=%h", score, score_exp);
        end
    endtask

    task automatic test_rst_midscan();
        int late;
        late = 0;
        clear_field();
        bx[0] = 100; by[0] = 200; bact[0] = 1'b1;
        ex[0] = 96;  ey[0] = 190; ealive[0] = 1'b1;
        drive_inputs();
        frame_tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk25);
            frame_tick = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bullet_hit !== '0 || enemy_kill !== '0 || score !== '0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL rst_midscan_outputs got hit=%h kill=%h score=%h busy=%b ovr=%b exp all 0",
                     bullet_hit, enemy_kill, score, busy, overrun);
        end
        @(negedge clk25);
        rst = 1'b0;
        score_exp = '0;
        repeat (40) begin
            @(negedge clk25);
            if (bullet_hit !== '0 || enemy_kill !== '0 || busy !== 1'b0 || score !== '0) late++;
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("FAIL rst_midscan_no_pulse got=%0d active_cycles exp=0", late);
        end
        run_frame("after_rst", 8'h01, 4'h1, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_touch();
        test_bullet_priority();
        test_enemy_priority();
        test_inactive();
        test_no_wrap();
        test_back_to_back();
        test_random();
        test_overrun();
        test_saturation();
        test_rst_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
